// File: rtl/priority_sequencer_if.sv
// Request/presentation bus between the channel front-end and the priority sequencer.
// The master drives the requests and commands, and the slave (the sequencer) presents the selected channel.
interface priority_sequencer_if #(
    parameter int N_CH = 16
);
    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(N_CH + 1);

    logic [N_CH-1:0]  ch_sel_i;
    logic             arm_i;
    logic             dump_i;
    logic             abort_i;
    logic [1:0]       mode_i;
    logic [N_CH-1:0]  ch_sel_o;
    logic [IDX_W-1:0] ch_idx_o;
    logic             valid_o;
    logic             zero_o;
    logic             busy_o;
    logic [CNT_W-1:0] pending_cnt_o;
    logic             cycle_done_o;

    modport master (
        output ch_sel_i, arm_i, dump_i, abort_i, mode_i,
        input  ch_sel_o, ch_idx_o, valid_o, zero_o, busy_o, pending_cnt_o, cycle_done_o
    );

    modport slave (
        input  ch_sel_i, arm_i, dump_i, abort_i, mode_i,
        output ch_sel_o, ch_idx_o, valid_o, zero_o, busy_o, pending_cnt_o, cycle_done_o
    );
endinterface

// File: rtl/priority_sequencer.sv
// Captures a set of channel requests and presents them one at a time in low-first, high-first or
// round-robin order, retiring one channel per dump and pulsing cycle_done when the set empties.
module priority_sequencer #(
    parameter int N_CH  = 16,
    parameter int IDX_W = $clog2(N_CH),
    parameter int CNT_W = $clog2(N_CH + 1)
) (
    input  logic                clk_i,
    input  logic                resetn_i,
    priority_sequencer_if.slave bus
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;
    localparam logic [1:0] M_HIGH   = 2'b01;
    localparam logic [1:0] M_RR     = 2'b10;

    logic [0:0]       r_state;
    logic [N_CH-1:0]  r_pending;
    logic [1:0]       r_mode;
    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_cycle_done;

    logic [IDX_W-1:0] w_lo_idx;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_rr_idx;
    logic             w_rr_hit;
    logic [IDX_W-1:0] w_idx;
    logic             w_valid;
    logic [N_CH-1:0]  w_sel;
    logic [N_CH-1:0]  w_pend_nxt;
    logic [IDX_W-1:0] w_rr_nxt;
    logic [CNT_W-1:0] w_cnt;

    // Descending scans let the last hit win, giving the lowest qualifying index.
    always_comb begin
        w_lo_idx = '0;
        w_hi_idx = '0;
        w_rr_idx = '0;
        w_rr_hit = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) w_lo_idx = IDX_W'(i);
        end
        for (int i = 0; i < N_CH; i++) begin
            if (r_pending[i]) w_hi_idx = IDX_W'(i);
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_pending[i] && (IDX_W'(i) >= r_rr_ptr)) begin
                w_rr_idx = IDX_W'(i);
                w_rr_hit = 1'b1;
            end
        end
        if (!w_rr_hit) w_rr_idx = w_lo_idx;

        w_idx = w_lo_idx;
        case (r_mode)
            M_HIGH:  w_idx = w_hi_idx;
            M_RR:    w_idx = w_rr_idx;
            default: w_idx = w_lo_idx;
        endcase
    end

    assign w_valid = |r_pending;
    assign w_sel   = w_valid ? ({{(N_CH-1){1'b0}}, 1'b1} << w_idx) : '0;

    // Clear-then-merge, so a channel re-requested in the same cycle it is served stays pending.
    assign w_pend_nxt = (r_pending & ~(bus.dump_i ? w_sel : '0))
                      | (bus.arm_i ? bus.ch_sel_i : '0);
    assign w_rr_nxt   = (w_idx == IDX_W'(N_CH - 1)) ? '0 : (w_idx + IDX_W'(1));

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cnt = w_cnt + CNT_W'(r_pending[i]);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_mode       <= 2'b00;
            r_rr_ptr     <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.arm_i && (|bus.ch_sel_i)) begin
                        r_pending <= bus.ch_sel_i;
                        r_mode    <= bus.mode_i;
                        r_state   <= S_ACTIVE;
                    end
                end
                default: begin
                    if (bus.abort_i) begin
                        r_pending <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_pending <= w_pend_nxt;
                        if (bus.dump_i && (r_mode == M_RR)) r_rr_ptr <= w_rr_nxt;
                        if (w_pend_nxt == '0) begin
                            r_state      <= S_IDLE;
                            r_cycle_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ch_sel_o      = w_sel;
    assign bus.ch_idx_o      = w_valid ? w_idx : '0;
    assign bus.valid_o       = w_valid;
    assign bus.zero_o        = !w_valid;
    assign bus.busy_o        = (r_state == S_ACTIVE);
    assign bus.pending_cnt_o = w_cnt;
    assign bus.cycle_done_o  = r_cycle_done;
endmodule

// File: tb/tb_priority_sequencer.sv
// Bench for priority_sequencer: directed vector table, hand-written corner sequences and
// randomized traffic compared against a set-based reference model.
module tb_priority_sequencer;
    localparam int N = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    priority_sequencer_if #(.N_CH(N)) bus ();

    priority_sequencer #(.N_CH(N)) dut (
        .clk_i    (clk),
        .resetn_i (rst_n),
        .bus      (bus.slave)
    );

    typedef struct {
        logic        arm;
        logic        dump;
        logic        abort;
        logic [1:0]  mode;
        logic [15:0] sel;
        int          idx;
        logic        valid;
        int          cnt;
        logic        done;
        logic        busy;
        logic [15:0] osel;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic a, logic d, logic ab, logic [1:0] m, logic [15:0] s,
                                int idx, logic v, int cnt, logic dn, logic b, logic [15:0] os);
        vec_t r;
        r.arm = a; r.dump = d; r.abort = ab; r.mode = m; r.sel = s;
        r.idx = idx; r.valid = v; r.cnt = cnt; r.done = dn; r.busy = b; r.osel = os;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(string tag, int idx, logic valid, int cnt, logic done,
                              logic busy, logic [15:0] osel);
        chk({tag, ".idx"},   32'(bus.ch_idx_o),      32'(idx));
        chk({tag, ".sel"},   32'(bus.ch_sel_o),      32'(osel));
        chk({tag, ".valid"}, 32'(bus.valid_o),       32'(valid));
        chk({tag, ".zero"},  32'(bus.zero_o),        32'(!valid));
        chk({tag, ".busy"},  32'(bus.busy_o),        32'(busy));
        chk({tag, ".cnt"},   32'(bus.pending_cnt_o), 32'(cnt));
        chk({tag, ".done"},  32'(bus.cycle_done_o),  32'(done));
    endtask

    task automatic drive(logic a, logic d, logic ab, logic [1:0] m, logic [15:0] s);
        bus.arm_i    = a;
        bus.dump_i   = d;
        bus.abort_i  = ab;
        bus.mode_i   = m;
        bus.ch_sel_i = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 2'b00, 16'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: pending set, served-order search as a circular scan, popcount by $countones.
    logic [15:0] m_pend;
    logic        m_act;
    logic [1:0]  m_mode;
    int          m_rr;
    logic        m_done;

    function automatic int m_pick();
        if (m_pend == 16'h0) return -1;
        if (m_mode == 2'b01) begin
            for (int i = N - 1; i >= 0; i--) if (m_pend[i]) return i;
        end else if (m_mode == 2'b10) begin
            for (int k = 0; k < N; k++) if (m_pend[(m_rr + k) % N]) return (m_rr + k) % N;
        end else begin
            for (int i = 0; i < N; i++) if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_pend = '0; m_act = 1'b0; m_mode = 2'b00; m_rr = 0; m_done = 1'b0;
    endtask

    task automatic m_step(logic a, logic d, logic ab, logic [1:0] m, logic [15:0] s);
        int p;
        m_done = 1'b0;
        if (!m_act) begin
            if (a && s != 16'h0) begin
                m_pend = s; m_mode = m; m_act = 1'b1;
            end
        end else if (ab) begin
            m_pend = '0; m_act = 1'b0;
        end else begin
            p = m_pick();
            if (d) begin
                m_pend[p] = 1'b0;
                if (m_mode == 2'b10) m_rr = (p + 1) % N;
            end
            if (a) m_pend = m_pend | s;
            if (m_pend == 16'h0) begin
                m_act = 1'b0; m_done = 1'b1;
            end
        end
    endtask

    task automatic check_model(string tag);
        int p;
        p = m_pick();
        expect_out(tag, (p < 0) ? 0 : p, (p >= 0), $countones(m_pend), m_done, m_act,
                   (p < 0) ? 16'h0 : (16'h1 << p));
    endtask

    initial begin
        drive(0, 0, 0, 2'b00, 16'h0);
        rst_n = 1'b0;
        #12;
        expect_out("reset", 0, 0, 0, 0, 0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Low-first drain, high-first drain, then IDLE ignores dump and empty arm.
        tbl[0]  = mk(1, 0, 0, 2'b00, 16'h8421, 0, 1, 4, 0, 1, 16'h0001);
        tbl[1]  = mk(0, 1, 0, 2'b00, 16'h0,    5, 1, 3, 0, 1, 16'h0020);
        tbl[2]  = mk(0, 1, 0, 2'b00, 16'h0,   10, 1, 2, 0, 1, 16'h0400);
        tbl[3]  = mk(0, 1, 0, 2'b00, 16'h0,   15, 1, 1, 0, 1, 16'h8000);
        tbl[4]  = mk(0, 1, 0, 2'b00, 16'h0,    0, 0, 0, 1, 0, 16'h0);
        tbl[5]  = mk(0, 0, 0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 16'h0);
        tbl[6]  = mk(1, 0, 0, 2'b01, 16'h0013, 4, 1, 3, 0, 1, 16'h0010);
        tbl[7]  = mk(0, 1, 0, 2'b00, 16'h0,    1, 1, 2, 0, 1, 16'h0002);
        tbl[8]  = mk(0, 1, 0, 2'b00, 16'h0,    0, 1, 1, 0, 1, 16'h0001);
        tbl[9]  = mk(0, 1, 0, 2'b00, 16'h0,    0, 0, 0, 1, 0, 16'h0);
        tbl[10] = mk(0, 0, 0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 16'h0);
        tbl[11] = mk(0, 1, 0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 16'h0);
        tbl[12] = mk(1, 0, 0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].arm, tbl[i].dump, tbl[i].abort, tbl[i].mode, tbl[i].sel);
            step();
            expect_out($sformatf("tbl%0d", i), tbl[i].idx, tbl[i].valid, tbl[i].cnt,
                       tbl[i].done, tbl[i].busy, tbl[i].osel);
        end

        // Round-robin: pointer advances past served channels, wraps, and survives abort.
        do_reset();
        drive(1, 0, 0, 2'b10, 16'h0011); step(); expect_out("rr.arm1",  0, 1, 2, 0, 1, 16'h0001);
        drive(0, 1, 0, 2'b00, 16'h0);    step(); expect_out("rr.d1",    4, 1, 1, 0, 1, 16'h0010);
        drive(0, 1, 0, 2'b00, 16'h0);    step(); expect_out("rr.d2",    0, 0, 0, 1, 0, 16'h0);
        drive(1, 0, 0, 2'b10, 16'h0011); step(); expect_out("rr.wrap",  0, 1, 2, 0, 1, 16'h0001);
        drive(0, 0, 1, 2'b00, 16'h0);    step(); expect_out("rr.abort", 0, 0, 0, 0, 0, 16'h0);
        drive(1, 0, 0, 2'b10, 16'h8001); step(); expect_out("rr.arm3", 15, 1, 2, 0, 1, 16'h8000);
        drive(0, 1, 0, 2'b00, 16'h0);    step(); expect_out("rr.d3",    0, 1, 1, 0, 1, 16'h0001);
        drive(0, 1, 0, 2'b00, 16'h0);    step(); expect_out("rr.d4",    0, 0, 0, 1, 0, 16'h0);

        // Same-cycle dump and re-request of the served channel keeps it pending.
        drive(1, 0, 0, 2'b00, 16'h0014); step(); expect_out("merge.arm", 2, 1, 2, 0, 1, 16'h0004);
        drive(1, 1, 0, 2'b00, 16'h0004); step(); expect_out("merge.dup", 2, 1, 2, 0, 1, 16'h0004);
        drive(0, 1, 0, 2'b00, 16'h0);    step(); expect_out("merge.d1",  4, 1, 1, 0, 1, 16'h0010);
        drive(0, 1, 0, 2'b00, 16'h0);    step(); expect_out("merge.d2",  0, 0, 0, 1, 0, 16'h0);

        // Abort wins over dump and produces no completion pulse.
        drive(1, 0, 0, 2'b00, 16'h00FF); step(); expect_out("ab.arm",  0, 1, 8, 0, 1, 16'h0001);
        drive(0, 1, 0, 2'b00, 16'h0);    step(); expect_out("ab.d1",   1, 1, 7, 0, 1, 16'h0002);
        drive(0, 1, 1, 2'b00, 16'h0);    step(); expect_out("ab.abort", 0, 0, 0, 0, 0, 16'h0);
        drive(0, 0, 0, 2'b00, 16'h0);    step(); expect_out("ab.after", 0, 0, 0, 0, 0, 16'h0);

        // Asynchronous reset mid-cycle, including one that drops a pending done pulse.
        drive(1, 0, 0, 2'b00, 16'h0F00); step(); expect_out("ar.arm", 8, 1, 4, 0, 1, 16'h0100);
        drive(0, 0, 0, 2'b00, 16'h0);
        #3; rst_n = 1'b0; #1;
        expect_out("ar.async", 0, 0, 0, 0, 0, 16'h0);
        #2; rst_n = 1'b1;
        drive(1, 0, 0, 2'b00, 16'h0);    step(); expect_out("ar.arm0", 0, 0, 0, 0, 0, 16'h0);
        drive(1, 0, 0, 2'b00, 16'h0001); step(); expect_out("dr.arm",  0, 1, 1, 0, 1, 16'h0001);
        drive(0, 1, 0, 2'b00, 16'h0);    step(); expect_out("dr.done", 0, 0, 0, 1, 0, 16'h0);
        drive(0, 0, 0, 2'b00, 16'h0);
        #3; rst_n = 1'b0; #1;
        expect_out("dr.drop", 0, 0, 0, 0, 0, 16'h0);
        #2; rst_n = 1'b1;

        // Randomized traffic against the reference model, with occasional async resets.
        do_reset();
        m_reset();
        for (int it = 0; it < 3000; it++) begin
            logic        a, d, ab;
            logic [1:0]  m;
            logic [15:0] s;
            a  = ($urandom_range(0, 9) < 3);
            d  = ($urandom_range(0, 1) == 1);
            ab = ($urandom_range(0, 29) == 0);
            m  = 2'($urandom_range(0, 3));
            s  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom & $urandom);
            if ($urandom_range(0, 199) == 0) begin
                drive(0, 0, 0, 2'b00, 16'h0);
                #3; rst_n = 1'b0; #1;
                m_reset();
                check_model($sformatf("rnd%0d.rst", it));
                #2; rst_n = 1'b1;
            end
            m_step(a, d, ab, m, s);
            drive(a, d, ab, m, s);
            step();
            check_model($sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
